shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
- Parametrised successor to the fixed 8-bit shift register: WIDTH-bit universal shift register with parallel load, seven shift modes and a multi-bit shift amount.
- Shift performed one bit per enabled cycle under a start/busy/done handshake.
- Serial in/out bits provided for chaining.
- Sits in the shifter library as the general-purpose sequential shifter for datapath and serialiser use.

Parameters:
- WIDTH, 8, data register width (>=2).
- AMT_W, 4, width of shift_amt; max request 2**AMT_W-1 bit positions.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global advance qualifier; low freezes all state.
- load  input  1  parallel load request (honoured in IDLE only).
- data_in  input  WIDTH  parallel load value.
- start  input  1  shift request (honoured in IDLE only).
- mode  input  3  shift mode, sampled with start.
- shift_amt  input  AMT_W  number of bit positions, sampled with start.
- serial_in  input  1  fill bit for serial modes.
- data_out  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted out.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate, any state): data_out=0, serial_out=0, busy=0, done=0, state=IDLE, internal count=0, latched mode=0.
- States: IDLE, SHIFT, DONE. State reg, count, data_out and serial_out update only on clk edges where enable=1; enable=0 holds everything, including the done pulse, which stays high until the next enabled edge.
- IDLE:
  - load=1: data_out<=data_in, stay IDLE. load has priority over start; start ignored that edge.
  - start=1, load=0, mode!=111: latch mode and count<=shift_amt; go to SHIFT if shift_amt!=0, else go to DONE.
  - mode=111 is reserved: start ignored, stay IDLE, no done.
- SHIFT: each enabled edge shifts one position and decrements count; move to DONE on the edge where count reaches 0. busy=1 throughout SHIFT. load/start are ignored.
- Modes (per step; MSB = bit WIDTH-1):
  - 000 logical left, 0 in at LSB, MSB out.
  - 001 logical right, 0 in at MSB, LSB out.
  - 010 rotate left, MSB wraps to LSB, and is also the out bit.
  - 011 rotate right, LSB wraps to MSB, and is also the out bit.
  - 100 arithmetic right, MSB replicated, LSB out.
  - 101 serial left, serial_in at LSB, MSB out.
  - 110 serial right, serial_in at MSB, LSB out.
- serial_out <= out bit on every shift step; it holds otherwise, including across load.
- Amounts >= WIDTH are not truncated. Logical shifts give 0; arithmetic gives all sign bits; rotates by WIDTH return the original value.
- DONE: done=1, busy=0 for exactly one enabled cycle, then IDLE. start/load in DONE are ignored.
- Latency: with start on enabled edge k and amount N>0, busy is high after edges k..k+N-1, and done is high after edge k+N. With N=0, done is high after edge k. Minimum start-to-start spacing is N+2 enabled edges.
- serial_in is sampled live on each step, not latched.

Optional Feature:
- Macro SHIFT_REG_BARREL_EN.
- When defined: SHIFT lasts exactly one enabled cycle regardless of amount. The full N-position result (same per-mode semantics, applied N times) is written in that cycle. serial_out = the last bit that the bit-serial version would have produced. Serial modes fill all N vacated bits with serial_in.
- When undefined: one bit per cycle as above.
- The port list is identical in both builds.

Test Plan:
- Reset mid-SHIFT: load 0x5A, start mode 000 amt 5, assert reset after 2 cycles -> data_out=0x00, busy=0, done=0, serial_out=0 immediately, without waiting for clk.
- Logical left: load 0xB4, start mode 000 amt 3 -> busy 3 cycles, then done 1 cycle, data_out=0xA0, serial_out=1.
- Rotate right: load 0x81, mode 011 amt 1 -> 0xC0. Then mode 011 amt 8 -> 0xC0 (full rotation, unchanged).
- Arithmetic right: load 0x90, mode 100 amt 2 -> 0xE4, serial_out=0. Serial left: load 0x00, serial_in=1, mode 101 amt 3 -> 0x07.
- Stall/priority: enable=0 for 2 cycles mid-shift -> busy held, count frozen, final value unchanged vs no stall. load+start together in IDLE -> load wins, no busy. load during SHIFT ignored.
- Corners: amt 0 -> done next cycle, data unchanged. mode 111 start -> no busy/done. Logical right amt 15 on 0xFF -> 0x00.
- Barrel build: mode 000 amt 3 on 0xB4 -> busy exactly 1 cycle, 0xA0, serial_out=1.

Source files
------------

// File: rtl/shift_reg_seq.sv
// WIDTH-bit universal sequential shifter: parallel load, seven shift modes, multi-bit amount, start/busy/done handshake.
// Define SHIFT_REG_BARREL_EN to complete any amount in a single SHIFT cycle instead of one bit per cycle.
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_AMT = (1 << AMT_W) - 1;

`ifdef SHIFT_REG_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    state_t           state_q;
    logic [AMT_W-1:0] count_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] data_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] stepData;
    logic             stepOut;
    logic [AMT_W-1:0] count_d;
    logic             lastStep;

    // One shift position; returns {out bit, shifted data}.
    function automatic logic [WIDTH:0] shiftStep(input logic [WIDTH-1:0] d,
                                                 input logic [2:0]       m,
                                                 input logic             sin);
        logic [WIDTH:0] r;
        case (m)
            3'b000:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            3'b001:  r = {d[0], 1'b0, d[WIDTH-1:1]};
            3'b010:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            3'b011:  r = {d[0], d[0], d[WIDTH-1:1]};
            3'b100:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            3'b101:  r = {d[WIDTH-1], d[WIDTH-2:0], sin};
            3'b110:  r = {d[0], sin, d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

`ifdef SHIFT_REG_BARREL_EN
    // Unrolled chain of single steps so every mode keeps its bit-serial meaning, including the last out bit.
    always_comb begin
        stepData = data_q;
        stepOut  = sout_q;
        for (int i = 0; i < MAX_AMT; i++) begin
            if (AMT_W'(i) < count_q) begin
                {stepOut, stepData} = shiftStep(stepData, mode_q, serial_in);
            end
        end
    end
`else
    always_comb begin
        {stepOut, stepData} = shiftStep(data_q, mode_q, serial_in);
    end
`endif

    assign lastStep = BARREL || (count_q == AMT_W'(1));
    assign count_d  = BARREL ? '0 : count_q - AMT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= 3'b000;
            data_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        data_q <= data_in;
                    end else if (start && (mode != 3'b111)) begin
                        mode_q  <= mode;
                        count_q <= shift_amt;
                        if (shift_amt != '0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    data_q  <= stepData;
                    sout_q  <= stepOut;
                    count_q <= count_d;
                    if (lastStep) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed corner cases plus randomized shifts against an arithmetic model.
// Expected cycle counts follow SHIFT_REG_BARREL_EN when the design is built with it.
module tb_shift_reg_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] data_in;
    logic       start;
    logic [2:0] mode;
    logic [3:0] shift_amt;
    logic       serial_in;
    logic [7:0] data_out;
    logic       serial_out;
    logic       busy;
    logic       done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] expData;
    logic       expSout;

    always #5 clk = ~clk;

    shift_reg_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .start      (start),
        .mode       (mode),
        .shift_amt  (shift_amt),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-form result of shifting n positions, plus the last bit a bit-serial shifter would emit.
    function automatic void modelShift(input logic [7:0] d, input logic [2:0] m, input int n,
                                       input logic sin, input logic prevOut,
                                       output logic [7:0] r, output logic o);
        int dv, sd, res, lim, k;
        dv  = int'(d);
        lim = (n < W) ? n : W;
        res = dv;
        o   = prevOut;
        if (n > 0) begin
            case (m)
                3'd0: begin res = dv << n; o = (n <= W) ? dv[W-n] : 1'b0; end
                3'd1: begin res = dv >> n; o = (n <= W) ? dv[n-1] : 1'b0; end
                3'd2: begin k = n % W; res = (dv << k) | (dv >> (W - k)); o = res[0]; end
                3'd3: begin k = n % W; res = (dv >> k) | (dv << (W - k)); o = res[W-1]; end
                3'd4: begin
                    sd  = dv[7] ? (dv | 32'hFFFF_FF00) : dv;
                    res = sd >>> n;
                    o   = (n <= W) ? dv[n-1] : dv[7];
                end
                3'd5: begin
                    res = (dv << n) | (sin ? ((1 << lim) - 1) : 0);
                    o   = (n <= W) ? dv[W-n] : sin;
                end
                3'd6: begin
                    res = (dv >> n) | (sin ? (32'hFF << (W - lim)) : 0);
                    o   = (n <= W) ? dv[n-1] : sin;
                end
                default: res = dv;
            endcase
        end
        r = res[7:0];
    endfunction

    task automatic loadValue(input logic [7:0] v);
        load      = 1'b1;
        data_in   = v;
        start     = 1'($urandom_range(0, 1));
        mode      = 3'd0;
        shift_amt = 4'd3;
        tick();
        load    = 1'b0;
        start   = 1'b0;
        expData = v;
        checkOutput("load_data", 32'(data_out), 32'(expData));
        checkOutput("load_busy", 32'(busy), 32'd0);
        checkOutput("load_done", 32'(done), 32'd0);
        checkOutput("load_sout_hold", 32'(serial_out), 32'(expSout));
    endtask

    task automatic applyStimulus(input logic [2:0] m, input int n, input logic sin,
                                 input int stallAt, input bit interfere);
        logic [7:0] newData;
        logic       newOut;
        logic [7:0] snap;
        int         cycles;
        int         expCycles;
        modelShift(expData, m, n, sin, expSout, newData, newOut);
`ifdef SHIFT_REG_BARREL_EN
        expCycles = (n > 0) ? 1 : 0;
`else
        expCycles = n;
`endif
        mode      = m;
        shift_amt = 4'(n);
        serial_in = sin;
        start     = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'(n > 0));
        checkOutput("done_after_start", 32'(done), 32'(n == 0));
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == stallAt) begin
                enable = 1'b0;
                snap   = data_out;
                repeat (2) tick();
                checkOutput("stall_busy", 32'(busy), 32'd1);
                checkOutput("stall_data", 32'(data_out), 32'(snap));
                enable = 1'b1;
            end
            if (interfere) begin
                load    = 1'b1;
                data_in = 8'($urandom);
                start   = 1'b1;
                mode    = 3'($urandom_range(0, 6));
            end
            tick();
            cycles++;
        end
        load    = 1'b0;
        start   = 1'b0;
        expData = newData;
        expSout = newOut;
        checkOutput("busy_cycles", 32'(cycles), 32'(expCycles));
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("result_data", 32'(data_out), 32'(expData));
        checkOutput("result_sout", 32'(serial_out), 32'(expSout));
        if (stallAt >= 0) begin
            enable = 1'b0;
            repeat (2) tick();
            checkOutput("done_held_stall", 32'(done), 32'd1);
            enable = 1'b1;
        end
        tick();
        checkOutput("done_cleared", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_data", 32'(data_out), 32'(expData));
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        load      = 1'b0;
        start     = 1'b0;
        data_in   = 8'h00;
        mode      = 3'd0;
        shift_amt = 4'd0;
        serial_in = 1'b0;
        expData   = 8'h00;
        expSout   = 1'b0;
        #12;
        checkOutput("reset_data", 32'(data_out), 32'h00);
        checkOutput("reset_sout", 32'(serial_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        loadValue(8'hB4);
        applyStimulus(3'd0, 3, 1'b0, -1, 1'b0);
        checkOutput("ll_const", 32'(data_out), 32'hA0);
        checkOutput("ll_sout_const", 32'(serial_out), 32'd1);

        loadValue(8'h81);
        applyStimulus(3'd3, 1, 1'b0, -1, 1'b0);
        checkOutput("rr1_const", 32'(data_out), 32'hC0);
        applyStimulus(3'd3, 8, 1'b0, -1, 1'b0);
        checkOutput("rr8_const", 32'(data_out), 32'hC0);

        loadValue(8'h90);
        applyStimulus(3'd4, 2, 1'b0, -1, 1'b0);
        checkOutput("asr_const", 32'(data_out), 32'hE4);
        checkOutput("asr_sout_const", 32'(serial_out), 32'd0);

        loadValue(8'h00);
        applyStimulus(3'd5, 3, 1'b1, -1, 1'b0);
        checkOutput("sl_const", 32'(data_out), 32'h07);

        loadValue(8'hFF);
        applyStimulus(3'd1, 15, 1'b0, -1, 1'b0);
        checkOutput("lsr15_const", 32'(data_out), 32'h00);

        loadValue(8'hB4);
        applyStimulus(3'd0, 3, 1'b0, 0, 1'b1);
        checkOutput("stall_const", 32'(data_out), 32'hA0);

        applyStimulus(3'd2, 0, 1'b0, -1, 1'b0);
        checkOutput("amt0_const", 32'(data_out), 32'hA0);

        // Reserved mode must neither start nor complete.
        mode      = 3'b111;
        shift_amt = 4'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("m7_busy", 32'(busy), 32'd0);
        checkOutput("m7_done", 32'(done), 32'd0);
        checkOutput("m7_data", 32'(data_out), 32'(expData));
        tick();
        checkOutput("m7_done_late", 32'(done), 32'd0);

        // load and start together: load wins.
        load      = 1'b1;
        start     = 1'b1;
        data_in   = 8'h3C;
        mode      = 3'd0;
        shift_amt = 4'd2;
        tick();
        load    = 1'b0;
        start   = 1'b0;
        expData = 8'h3C;
        checkOutput("prio_data", 32'(data_out), 32'h3C);
        checkOutput("prio_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("prio_busy_late", 32'(busy), 32'd0);
        checkOutput("prio_done_late", 32'(done), 32'd0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) loadValue(8'($urandom));
            applyStimulus(3'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                          1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a shift.
        loadValue(8'h5A);
        mode      = 3'd0;
        shift_amt = 4'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checkOutput("pre_reset_data", 32'(data_out), 32'h68);
        checkOutput("pre_reset_sout", 32'(serial_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_data", 32'(data_out), 32'h00);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_done", 32'(done), 32'd0);
        checkOutput("async_reset_sout", 32'(serial_out), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
